pipeline_interlock_ctrl: RTL and testbench
==========================================

Name: pipeline_interlock_ctrl

Overview:
Hazard and interlock controller for the 5-stage pipeline (IF, OF, EX, MA, RW).
- Generates the data- and branch-interlock signals consumed by the OF/EX pipeline latch, which inserts a NOP bubble (IR 32'h68000000, control bus 0) when either is high.
- Generates the PC/IF-OF hold signal.
- Tracks in-flight destination registers in a 3-entry scoreboard, sequences multi-cycle divide occupancy of EX, and counts data-stall cycles for performance debug.

Parameters:
REG_W, 4, register-address width (16 architectural registers)
FORWARDING, 1, 1 = forwarding present (only load-use stalls); 0 = stall on any RAW against EX/MA/RW
BRANCH_BUBBLES, 2, bubble cycles inserted after a taken branch resolves in EX (range 1..7)
DIV_CYCLES, 4, EX occupancy of a divide/modulo instruction (range 1..15)

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
of_valid  in  1  OF stage holds a real instruction
of_src1  in  REG_W  first source register
of_src1_used  in  1  src1 is read
of_src2  in  REG_W  second source register (rs2, or rd for st)
of_src2_used  in  1  src2 is read
of_dst  in  REG_W  destination register
of_writes  in  1  instruction writes the register file
of_is_load  in  1  instruction is ld
of_is_div  in  1  instruction is div/mod
ex_branch_taken  in  1  EX resolved a taken branch/call/ret this cycle
isDataInterLock  out  1  OF/EX latch injects a bubble due to a data/structural hazard
isBranchInterLock  out  1  OF/EX latch injects a bubble due to a taken branch
pc_stall  out  1  hold PC and the IF/OF latch
div_busy  out  1  divide is occupying EX
stall_count  out  16  saturating count of data-interlock cycles

Behaviour:
- Reset (async): scoreboard entries invalid, branch_cnt=0, div_cnt=0, stall_count=0. All outputs 0 while reset is high.
- Outputs are combinational from registered state and current OF/EX inputs. They settle within the high phase so the OF/EX latch samples them at the falling edge.
- Scoreboard: entries EX, MA, RW, each holding {valid, dst, is_load}.
  - Each rising edge: RW<=MA, MA<=EX.
  - EX<= {of_valid & of_writes, of_dst, of_is_load} when no interlock is asserted; otherwise EX<= invalid.
  - While div_busy, EX holds its contents and MA<= invalid.
- match(e) = e.valid & ((of_src1_used & of_src1==e.dst) | (of_src2_used & of_src2==e.dst)).
- raw_hazard:
  - FORWARDING=1: match(EX) & EX.is_load (load-use).
  - FORWARDING=0: match(EX) | match(MA) | match(RW).
- Divide sequencing:
  - A non-interlocked OF instruction with of_is_div loads div_cnt=DIV_CYCLES-1 on entering EX.
  - div_busy = (div_cnt!=0); div_cnt decrements each cycle while nonzero.
  - DIV_CYCLES=1 never asserts div_busy.
- Branch sequencing:
  - ex_branch_taken loads branch_cnt=BRANCH_BUBBLES-1.
  - branch_cnt decrements to 0 thereafter.
  - A new taken branch while counting cannot occur; branch_cnt reloads regardless.
- isBranchInterLock = ex_branch_taken | (branch_cnt!=0).
- isDataInterLock = of_valid & ~isBranchInterLock & (raw_hazard | div_busy).
- pc_stall = isDataInterLock. Never asserted with isBranchInterLock, because the PC is being redirected.
- Priority: branch flush beats data interlock. A hazard against an instruction being flushed is ignored.
- Divide in flight and taken branch in the same cycle: div_cnt keeps counting. Branch bubbles overlap with and do not extend the divide stall.
- stall_count increments by 1 on each rising edge with isDataInterLock=1 and saturates at 16'hFFFF.
- Reset asserted mid-branch or mid-divide: all counters clear immediately. The first cycle after deassertion has no interlock.
- Register equality is full REG_W-bit compare; no register is treated as hardwired.

Test Plan:
- FORWARDING=1: ld r3 enters EX, OF holds add r5,r3,r4 -> isDataInterLock=1, pc_stall=1 for exactly 1 cycle, then 0; stall_count=1.
- FORWARDING=0: add r2,r1,r1 then sub r6,r2,r7 back-to-back -> isDataInterLock=1 for 3 consecutive cycles; stall_count=3.
- ex_branch_taken pulsed 1 cycle, BRANCH_BUBBLES=2 -> isBranchInterLock=1 for 2 cycles, pc_stall=0 throughout; a load-use pattern present in OF during those cycles gives isDataInterLock=0.
- div r1,r2,r3 with DIV_CYCLES=4, followed by an independent add -> div_busy=1 and isDataInterLock=1 for 3 cycles; add enters EX on the 4th cycle after div.
- Assert reset while branch_cnt=1 and div_cnt=2 -> all outputs 0 immediately and stall_count=0; after release, an independent instruction proceeds with no bubble.
- Force 65,536 data-stall cycles -> stall_count holds at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/pipeline_interlock_ctrl.sv
// Hazard/interlock controller for the IF-OF-EX-MA-RW pipeline: bubble requests, PC hold, divide occupancy, stall counter.
// Outputs are combinational from registered state and OF/EX inputs; the OF/EX latch samples them at the falling edge.
module pipeline_interlock_ctrl #(
    parameter int REG_W          = 4,
    parameter int FORWARDING     = 1,
    parameter int BRANCH_BUBBLES = 2,
    parameter int DIV_CYCLES     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             of_valid,
    input  logic [REG_W-1:0] of_src1,
    input  logic             of_src1_used,
    input  logic [REG_W-1:0] of_src2,
    input  logic             of_src2_used,
    input  logic [REG_W-1:0] of_dst,
    input  logic             of_writes,
    input  logic             of_is_load,
    input  logic             of_is_div,
    input  logic             ex_branch_taken,
    output logic             isDataInterLock,
    output logic             isBranchInterLock,
    output logic             pc_stall,
    output logic             div_busy,
    output logic [15:0]      stall_count
);

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] dst;
        logic             is_load;
    } ex_entry_t;

    // The load flag only matters while the producer sits in EX, so later stages drop it.
    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] dst;
    } sb_entry_t;

    localparam logic FWD_OFF = (FORWARDING == 0);

    ex_entry_t  ex_q;
    sb_entry_t  ma_q;
    sb_entry_t  rw_q;
    logic [2:0] branch_cnt;
    logic [3:0] div_cnt;

    logic m_ex, m_ma, m_rw;
    logic raw_hazard, busy, br_il, data_il, any_il, div_start;

    assign m_ex = ex_q.vld & ((of_src1_used & (of_src1 == ex_q.dst)) |
                              (of_src2_used & (of_src2 == ex_q.dst)));
    assign m_ma = ma_q.vld & ((of_src1_used & (of_src1 == ma_q.dst)) |
                              (of_src2_used & (of_src2 == ma_q.dst)));
    assign m_rw = rw_q.vld & ((of_src1_used & (of_src1 == rw_q.dst)) |
                              (of_src2_used & (of_src2 == rw_q.dst)));

    // With forwarding only a load in EX stalls; without it any in-flight producer does.
    assign raw_hazard = (m_ex & (ex_q.is_load | FWD_OFF)) | (FWD_OFF & (m_ma | m_rw));

    assign busy      = (div_cnt != 4'd0);
    assign br_il     = ~reset & (ex_branch_taken | (branch_cnt != 3'd0));
    assign data_il   = ~reset & of_valid & ~br_il & (raw_hazard | busy);
    assign any_il    = br_il | data_il;
    assign div_start = of_valid & of_is_div & ~any_il & ~busy;

    assign isDataInterLock   = data_il;
    assign isBranchInterLock = br_il;
    assign pc_stall          = data_il;
    assign div_busy          = ~reset & busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            ma_q        <= '0;
            rw_q        <= '0;
            branch_cnt  <= 3'd0;
            div_cnt     <= 4'd0;
            stall_count <= 16'd0;
        end else begin
            rw_q <= ma_q;
            // A divide parks in EX, so nothing advances into MA behind it.
            if (busy) begin
                ma_q <= '0;
            end else begin
                ma_q.vld <= ex_q.vld;
                ma_q.dst <= ex_q.dst;
                if (any_il) begin
                    ex_q <= '0;
                end else begin
                    ex_q.vld     <= of_valid & of_writes;
                    ex_q.dst     <= of_dst;
                    ex_q.is_load <= of_is_load;
                end
            end

            if (div_start)
                div_cnt <= 4'(DIV_CYCLES - 1);
            else if (busy)
                div_cnt <= div_cnt - 4'd1;

            if (ex_branch_taken)
                branch_cnt <= 3'(BRANCH_BUBBLES - 1);
            else if (branch_cnt != 3'd0)
                branch_cnt <= branch_cnt - 3'd1;

            if (data_il && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Directed bench for pipeline_interlock_ctrl: forwarding, non-forwarding and long-divide instances share one OF/EX stimulus.
module tb_pipeline_interlock_ctrl;

    logic       clk, reset;
    logic       of_valid, of_src1_used, of_src2_used, of_writes, of_is_load, of_is_div, ex_branch_taken;
    logic [3:0] of_src1, of_src2, of_dst;

    logic        f_dil, f_bil, f_pcs, f_busy;
    logic [15:0] f_cnt;
    logic        n_dil, n_bil, n_pcs, n_busy;
    logic [15:0] n_cnt;
    logic        s_dil, s_bil, s_pcs, s_busy;
    logic [15:0] s_cnt;

    int checks = 0;
    int passed = 0;

    pipeline_interlock_ctrl #(.REG_W(4), .FORWARDING(1), .BRANCH_BUBBLES(2), .DIV_CYCLES(4)) dut_f (
        .clk(clk), .reset(reset), .of_valid(of_valid),
        .of_src1(of_src1), .of_src1_used(of_src1_used), .of_src2(of_src2), .of_src2_used(of_src2_used),
        .of_dst(of_dst), .of_writes(of_writes), .of_is_load(of_is_load), .of_is_div(of_is_div),
        .ex_branch_taken(ex_branch_taken), .isDataInterLock(f_dil), .isBranchInterLock(f_bil),
        .pc_stall(f_pcs), .div_busy(f_busy), .stall_count(f_cnt));

    pipeline_interlock_ctrl #(.REG_W(4), .FORWARDING(0), .BRANCH_BUBBLES(2), .DIV_CYCLES(1)) dut_n (
        .clk(clk), .reset(reset), .of_valid(of_valid),
        .of_src1(of_src1), .of_src1_used(of_src1_used), .of_src2(of_src2), .of_src2_used(of_src2_used),
        .of_dst(of_dst), .of_writes(of_writes), .of_is_load(of_is_load), .of_is_div(of_is_div),
        .ex_branch_taken(ex_branch_taken), .isDataInterLock(n_dil), .isBranchInterLock(n_bil),
        .pc_stall(n_pcs), .div_busy(n_busy), .stall_count(n_cnt));

    pipeline_interlock_ctrl #(.REG_W(4), .FORWARDING(1), .BRANCH_BUBBLES(2), .DIV_CYCLES(15)) dut_s (
        .clk(clk), .reset(reset), .of_valid(of_valid),
        .of_src1(of_src1), .of_src1_used(of_src1_used), .of_src2(of_src2), .of_src2_used(of_src2_used),
        .of_dst(of_dst), .of_writes(of_writes), .of_is_load(of_is_load), .of_is_div(of_is_div),
        .ex_branch_taken(ex_branch_taken), .isDataInterLock(s_dil), .isBranchInterLock(s_bil),
        .pc_stall(s_pcs), .div_busy(s_busy), .stall_count(s_cnt));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                          input logic u2, input logic [3:0] d, input logic w, input logic ld, input logic dv);
        of_valid = v; of_src1 = s1; of_src1_used = u1; of_src2 = s2; of_src2_used = u2;
        of_dst = d; of_writes = w; of_is_load = ld; of_is_div = dv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ex_branch_taken = 1'b1;
        set_op(1, 4'd3, 1, 4'd4, 1, 4'd5, 1, 1, 1);
        #7;
        checks++; if (f_dil !== 1'b0) $display("FAIL rst_dil: got %b want 0", f_dil); else passed++;
        checks++; if (f_bil !== 1'b0) $display("FAIL rst_bil: got %b want 0", f_bil); else passed++;
        checks++; if (f_pcs !== 1'b0) $display("FAIL rst_pcs: got %b want 0", f_pcs); else passed++;
        checks++; if (f_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", f_busy); else passed++;
        checks++; if (f_cnt !== 16'd0) $display("FAIL rst_cnt: got %h want 0000", f_cnt); else passed++;
        ex_branch_taken = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_op(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);          // ld r3
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL lu_ld_free: got %b want 0", f_dil); else passed++;
        tick();
        set_op(1, 4'd3, 1, 4'd4, 1, 4'd5, 1, 0, 0);          // add r5,r3,r4
        #1;
        checks++; if (f_dil !== 1'b1) $display("FAIL lu_dil: got %b want 1", f_dil); else passed++;
        checks++; if (f_pcs !== 1'b1) $display("FAIL lu_pcs: got %b want 1", f_pcs); else passed++;
        tick();
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL lu_dil_clear: got %b want 0", f_dil); else passed++;
        checks++; if (f_pcs !== 1'b0) $display("FAIL lu_pcs_clear: got %b want 0", f_pcs); else passed++;
        checks++; if (f_cnt !== 16'd1) $display("FAIL lu_cnt: got %h want 0001", f_cnt); else passed++;
        tick();
        set_op(1, 4'd5, 1, 4'd0, 0, 4'd6, 1, 0, 0);          // reader of an ALU result in EX
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL lu_alu_fwd: got %b want 0", f_dil); else passed++;
    endtask

    task automatic test_raw_nofwd();
        do_reset();
        set_op(1, 4'd1, 1, 4'd1, 1, 4'd2, 1, 0, 0);          // add r2,r1,r1
        #1;
        checks++; if (n_dil !== 1'b0) $display("FAIL nf_first: got %b want 0", n_dil); else passed++;
        tick();
        set_op(1, 4'd2, 1, 4'd7, 1, 4'd6, 1, 0, 0);          // sub r6,r2,r7
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL nf_fwd_inst: got %b want 0", f_dil); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (n_dil !== 1'b1) $display("FAIL nf_stall%0d: got %b want 1", i, n_dil); else passed++;
            checks++; if (n_pcs !== 1'b1) $display("FAIL nf_pcs%0d: got %b want 1", i, n_pcs); else passed++;
            tick();
            #1;
        end
        checks++; if (n_dil !== 1'b0) $display("FAIL nf_release: got %b want 0", n_dil); else passed++;
        checks++; if (n_cnt !== 16'd3) $display("FAIL nf_cnt: got %h want 0003", n_cnt); else passed++;

        do_reset();
        set_op(1, 4'd0, 0, 4'd0, 0, 4'd2, 0, 0, 0);          // non-writing op naming r2
        tick();
        set_op(1, 4'd2, 1, 4'd0, 0, 4'd3, 0, 0, 0);
        #1;
        checks++; if (n_dil !== 1'b0) $display("FAIL nf_nowrite: got %b want 0", n_dil); else passed++;
        tick();
        set_op(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 0, 0);          // writer of r0
        tick();
        set_op(1, 4'd9, 1, 4'd0, 0, 4'd4, 1, 0, 0);
        #1;
        checks++; if (n_dil !== 1'b0) $display("FAIL nf_src2_unused: got %b want 0", n_dil); else passed++;
        of_src2_used = 1'b1;
        #1;
        checks++; if (n_dil !== 1'b1) $display("FAIL nf_r0_hazard: got %b want 1", n_dil); else passed++;
        of_valid = 1'b0;
        #1;
        checks++; if (n_dil !== 1'b0) $display("FAIL nf_invalid_of: got %b want 0", n_dil); else passed++;
    endtask

    task automatic test_branch();
        do_reset();
        set_op(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);          // ld r3
        tick();
        set_op(1, 4'd3, 1, 4'd4, 1, 4'd5, 1, 0, 0);          // load-use shadowed by the flush
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (f_bil !== 1'b1) $display("FAIL br_bil0: got %b want 1", f_bil); else passed++;
        checks++; if (f_dil !== 1'b0) $display("FAIL br_dil0: got %b want 0", f_dil); else passed++;
        checks++; if (f_pcs !== 1'b0) $display("FAIL br_pcs0: got %b want 0", f_pcs); else passed++;
        checks++; if (n_dil !== 1'b0) $display("FAIL br_nf_dil0: got %b want 0", n_dil); else passed++;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (f_bil !== 1'b1) $display("FAIL br_bil1: got %b want 1", f_bil); else passed++;
        checks++; if (f_dil !== 1'b0) $display("FAIL br_dil1: got %b want 0", f_dil); else passed++;
        checks++; if (f_pcs !== 1'b0) $display("FAIL br_pcs1: got %b want 0", f_pcs); else passed++;
        tick();
        #1;
        checks++; if (f_bil !== 1'b0) $display("FAIL br_bil_end: got %b want 0", f_bil); else passed++;
        checks++; if (f_dil !== 1'b0) $display("FAIL br_dil_end: got %b want 0", f_dil); else passed++;
        checks++; if (n_dil !== 1'b1) $display("FAIL br_nf_rw_hazard: got %b want 1", n_dil); else passed++;
        checks++; if (f_cnt !== 16'd0) $display("FAIL br_cnt: got %h want 0000", f_cnt); else passed++;
    endtask

    task automatic test_divide();
        do_reset();
        set_op(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 1);          // div r1,r2,r3
        #1;
        checks++; if (f_busy !== 1'b0) $display("FAIL dv_idle_busy: got %b want 0", f_busy); else passed++;
        checks++; if (f_dil !== 1'b0) $display("FAIL dv_idle_dil: got %b want 0", f_dil); else passed++;
        tick();
        set_op(1, 4'd9, 1, 4'd0, 0, 4'd8, 1, 1, 0);          // independent ld r8
        #1;
        checks++; if (n_busy !== 1'b0) $display("FAIL dv_one_cycle_busy: got %b want 0", n_busy); else passed++;
        checks++; if (n_dil !== 1'b0) $display("FAIL dv_one_cycle_dil: got %b want 0", n_dil); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (f_busy !== 1'b1) $display("FAIL dv_busy%0d: got %b want 1", i, f_busy); else passed++;
            checks++; if (f_dil !== 1'b1) $display("FAIL dv_dil%0d: got %b want 1", i, f_dil); else passed++;
            tick();
            #1;
        end
        checks++; if (f_busy !== 1'b0) $display("FAIL dv_busy_end: got %b want 0", f_busy); else passed++;
        checks++; if (f_dil !== 1'b0) $display("FAIL dv_dil_end: got %b want 0", f_dil); else passed++;
        checks++; if (f_cnt !== 16'd3) $display("FAIL dv_cnt: got %h want 0003", f_cnt); else passed++;
        tick();
        set_op(1, 4'd8, 1, 4'd8, 1, 4'd10, 1, 0, 0);         // consumer of r8 sees it in EX
        #1;
        checks++; if (f_dil !== 1'b1) $display("FAIL dv_follower_in_ex: got %b want 1", f_dil); else passed++;
    endtask

    task automatic test_div_branch_reset();
        do_reset();
        set_op(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 1, 0);
        tick();
        set_op(1, 4'd3, 1, 4'd4, 1, 4'd5, 1, 0, 0);
        tick();
        tick();
        set_op(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0, 1);          // div enters EX at next edge
        #1;
        checks++; if (f_cnt !== 16'd1) $display("FAIL dbr_cnt_pre: got %h want 0001", f_cnt); else passed++;
        tick();
        set_op(1, 4'd9, 1, 4'd10, 1, 4'd11, 1, 0, 0);
        ex_branch_taken = 1'b1;
        #1;
        checks++; if (f_busy !== 1'b1) $display("FAIL dbr_busy0: got %b want 1", f_busy); else passed++;
        checks++; if (f_bil !== 1'b1) $display("FAIL dbr_bil0: got %b want 1", f_bil); else passed++;
        checks++; if (f_dil !== 1'b0) $display("FAIL dbr_dil0: got %b want 0", f_dil); else passed++;
        checks++; if (f_pcs !== 1'b0) $display("FAIL dbr_pcs0: got %b want 0", f_pcs); else passed++;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++; if (f_busy !== 1'b1) $display("FAIL dbr_busy1: got %b want 1", f_busy); else passed++;
        checks++; if (f_bil !== 1'b1) $display("FAIL dbr_bil1: got %b want 1", f_bil); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL dbr_rst_dil: got %b want 0", f_dil); else passed++;
        checks++; if (f_bil !== 1'b0) $display("FAIL dbr_rst_bil: got %b want 0", f_bil); else passed++;
        checks++; if (f_pcs !== 1'b0) $display("FAIL dbr_rst_pcs: got %b want 0", f_pcs); else passed++;
        checks++; if (f_busy !== 1'b0) $display("FAIL dbr_rst_busy: got %b want 0", f_busy); else passed++;
        checks++; if (f_cnt !== 16'd0) $display("FAIL dbr_rst_cnt: got %h want 0000", f_cnt); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL dbr_post_dil: got %b want 0", f_dil); else passed++;
        checks++; if (f_bil !== 1'b0) $display("FAIL dbr_post_bil: got %b want 0", f_bil); else passed++;
        tick();
        #1;
        checks++; if (f_dil !== 1'b0) $display("FAIL dbr_post2_dil: got %b want 0", f_dil); else passed++;
        checks++; if (f_bil !== 1'b0) $display("FAIL dbr_post2_bil: got %b want 0", f_bil); else passed++;
        checks++; if (f_busy !== 1'b0) $display("FAIL dbr_post2_busy: got %b want 0", f_busy); else passed++;
        checks++; if (f_cnt !== 16'd0) $display("FAIL dbr_post2_cnt: got %h want 0000", f_cnt); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        set_op(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1);          // back-to-back 15-cycle divides
        // Every 15th edge admits a divide, the other 14 are stalls: 70200 edges -> 65520 stalls.
        repeat (70200) @(posedge clk);
        #1;
        checks++; if (s_cnt !== 16'hFFF0) $display("FAIL sat_pre: got %h want fff0", s_cnt); else passed++;
        repeat (30) @(posedge clk);
        #1;
        checks++; if (s_cnt !== 16'hFFFF) $display("FAIL sat_hit: got %h want ffff", s_cnt); else passed++;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (s_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", s_cnt); else passed++;
        set_op(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
    endtask

    initial begin
        ex_branch_taken = 1'b0;
        set_op(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_raw_nofwd();
        test_branch();
        test_divide();
        test_div_branch_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
